instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
Single-issue instruction fetch stage that sits directly upstream of the opcode decoder/control unit. Holds the PC and issues word fetches to instruction memory over a req/ready handshake. Presents the fetched instruction, its opcode field and the sign-extended immediate to decode. Applies sequential or branch-redirected PC update when decode/execute releases the instruction.

Parameters:
RESET_PC  32'h0000_0000  PC loaded on reset; must be word-aligned (bits [1:0] ignored, forced 0)

Ports:
clk            input   1   clock, rising edge
rst            input   1   reset, synchronous, active-high
imem_req       output  1   fetch request to instruction memory
imem_addr      output  32  fetch address (word-aligned PC)
imem_rdata     input   32  instruction word from memory, valid when imem_ready=1
imem_ready     input   1   memory accepts request and returns data this cycle
stall          input   1   downstream not ready; hold current instruction
branch_taken   input   1   branch & zero for the delivered instruction; sampled only on release
instr          output  32  delivered instruction; 32'h0 (nop) when instr_valid=0
instr_op       output  6   instr[31:26], feeds decoder opcode input
imm_sext       output  32  sign-extended instr[15:0]
instr_valid    output  1   instr/instr_op/imm_sext valid
pc             output  32  PC of the delivered instruction
pc_plus4       output  32  pc + 4, modulo 2^32
fetch_count    output  32  number of instructions released since reset, wraps

Behaviour:
- Reset: on the rst=1 clock edge: state=FETCH, pc=RESET_PC&~3, instr register=0, instr_valid=0, fetch_count=0. While rst=1, imem_req=0. rst overrides every other input.
- Reset mid-operation: aborts any outstanding request with no completion. Instruction memory shares rst, so no stale response can follow. The first cycle after rst deasserts is FETCH at RESET_PC.
- FSM states: FETCH, DELIVER.
- FETCH:
  - imem_req=1, imem_addr=pc; both held stable until imem_ready=1.
  - On the edge where imem_ready=1: capture imem_rdata into the instr register, set instr_valid=1, go to DELIVER.
  - Zero-wait memory (ready in the first FETCH cycle) gives instr_valid on the next cycle.
  - instr_valid=0 and instr reads 32'h0 throughout FETCH.
- DELIVER:
  - imem_req=0; instr_valid=1; instr, pc and pc_plus4 held stable.
  - stall=1: remain in DELIVER, nothing changes; branch_taken is ignored.
  - stall=0 (release):
    - If branch_taken=1: pc <= pc_plus4 + (imm_sext<<2).
    - Else: pc <= pc_plus4.
    - fetch_count increments, instr_valid <= 0, go to FETCH.
- Throughput: a minimum of 2 cycles per instruction; N memory wait cycles add N.
- Arithmetic: all PC arithmetic is 32-bit modulo, with wrap-around allowed (0xFFFF_FFFC+4 = 0). Backward branches use two's-complement imm_sext. pc[1:0] is always 0.
- Derived outputs: instr_op, imm_sext and pc_plus4 are combinational from the instr and pc registers. instr_op = 6'b000000 when invalid; the decoder's consumers must qualify it with instr_valid.
- imem_ready while in DELIVER: ignored.
- branch_taken while in FETCH: ignored.

Decomposition:
- Shared package (cpu_pkg):
  - Opcode constants: R=6'b000000, LW=6'b100011, SW=6'b101011, BEQ=6'b000100, ADDI=6'b001000.
  - NOP=32'h0 and WORD_BYTES=4.
  - The fetch state enum.
- No sub-module is needed. PC next-value logic stays inline as a small always block.

Test Plan:
- Reset with RESET_PC=32'h0000_0040, zero-wait memory returning 32'h8C01_0004 → imem_addr=0x40 the cycle after reset; next cycle instr_valid=1, instr_op=6'b100011, imm_sext=4, pc=0x40, pc_plus4=0x44.
- Memory with 3 wait cycles → imem_req and imem_addr stable for 4 cycles; instr_valid=0 and instr=0 throughout; a single capture on ready.
- Hold stall=1 for 5 cycles in DELIVER, toggling branch_taken → outputs frozen and no fetch issued; on release with branch_taken=0, the next imem_addr is pc+4 and fetch_count=1.
- BEQ 32'h1000_FFFE at pc=0x100, branch_taken=1 on release → next imem_addr=0x104+(-2<<2)=0x0FC. With a forward offset 3 the next address is 0x110.
- PC wrap: pc=0xFFFF_FFFC, no branch → next imem_addr=0x0000_0000.
- Assert rst during a FETCH wait and during DELIVER → the next cycle has imem_req=0, instr_valid=0 and fetch_count=0; the fetch then restarts at RESET_PC.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode constants, nop word, word size, fetch FSM state.
// Imported by the fetch unit and by the downstream decoder so both agree on
// opcode encodings and instruction-word layout.
package cpu_pkg;

   // Primary opcode field values (instr[31:26])
   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_ADDI = 6'b001000;

   // All-zero word decodes as an R-type no-op
   localparam logic [31:0] NOP = 32'h0000_0000;

   localparam int unsigned WORD_BYTES = 4;

   // Fetch stage states: waiting on memory, or holding an instruction for decode
   typedef enum logic [0:0] {
      ST_FETCH   = 1'b0,
      ST_DELIVER = 1'b1
   } fetch_state_e;

   function automatic logic [31:0] sext16(input logic [15:0] v);
      return {{16{v[15]}}, v};
   endfunction

endpackage

// File: rtl/instr_fetch_unit.sv
// Single-issue instruction fetch stage: holds the PC, fetches one word at a time
// from instruction memory and presents it (with opcode and sign-extended
// immediate) to decode until decode releases it with stall=0.
// Ports: clk/rst (sync, active-high); imem_req/imem_addr/imem_rdata/imem_ready
// memory handshake; stall/branch_taken from decode/execute; instr, instr_op,
// imm_sext, instr_valid, pc, pc_plus4, fetch_count towards decode.
module instr_fetch_unit
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        imem_ready,
   input  logic        stall,
   input  logic        branch_taken,
   output logic [31:0] instr,
   output logic [5:0]  instr_op,
   output logic [31:0] imm_sext,
   output logic        instr_valid,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic [31:0] fetch_count
);

   // Low address bits are dropped so a misaligned parameter still fetches words
   localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

   fetch_state_e state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic [31:0]  instr_q, instr_d;
   logic         instr_valid_q, instr_valid_d;
   logic [31:0]  fetch_count_q, fetch_count_d;
   logic [31:0]  branch_target;

   // Derived outputs: instr is forced to a nop whenever nothing is held,
   // so opcode and immediate read as zero during FETCH
   assign instr       = instr_valid_q ? instr_q : NOP;
   assign instr_op    = instr[31:26];
   assign imm_sext    = sext16(instr[15:0]);
   assign instr_valid = instr_valid_q;
   assign pc          = pc_q;
   assign pc_plus4    = pc_q + WORD_BYTES;
   assign fetch_count = fetch_count_q;

   // Request is gated by rst so nothing is issued while reset is held,
   // even though the state register already reads FETCH
   assign imem_req  = (state_q == ST_FETCH) && !rst;
   assign imem_addr = pc_q;

   // Word offset shifted into a byte offset; keeps pc[1:0] at zero
   assign branch_target = pc_plus4 + {imm_sext[29:0], 2'b00};

   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      instr_d       = instr_q;
      instr_valid_d = instr_valid_q;
      fetch_count_d = fetch_count_q;
      case (state_q)
         ST_FETCH: begin
            if (imem_ready) begin
               instr_d       = imem_rdata;
               instr_valid_d = 1'b1;
               state_d       = ST_DELIVER;
            end
         end
         ST_DELIVER: begin
            // branch_taken only matters on the releasing cycle
            if (!stall) begin
               pc_d          = branch_taken ? branch_target : pc_plus4;
               fetch_count_d = fetch_count_q + 32'd1;
               instr_d       = NOP;
               instr_valid_d = 1'b0;
               state_d       = ST_FETCH;
            end
         end
         default: begin
            state_d = ST_FETCH;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_FETCH;
         pc_q          <= RESET_PC_ALIGNED;
         instr_q       <= NOP;
         instr_valid_q <= 1'b0;
         fetch_count_q <= 32'd0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         instr_q       <= instr_d;
         instr_valid_q <= instr_valid_d;
         fetch_count_q <= fetch_count_d;
      end
   end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed fetch/stall/branch/reset
// sequences with literal expectations, plus a per-cycle comparison against a
// transaction-level model of the fetch stage.
module tb_instr_fetch_unit;

   localparam logic [31:0] TB_RESET_PC = 32'h0000_0040;

   logic        clk;
   logic        rst;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        imem_ready;
   logic        stall;
   logic        branch_taken;
   logic [31:0] instr;
   logic [5:0]  instr_op;
   logic [31:0] imm_sext;
   logic        instr_valid;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic [31:0] fetch_count;

   int n_cmp = 0;
   int n_bad = 0;

   instr_fetch_unit #(.RESET_PC(TB_RESET_PC)) dut (
      .clk          (clk),
      .rst          (rst),
      .imem_req     (imem_req),
      .imem_addr    (imem_addr),
      .imem_rdata   (imem_rdata),
      .imem_ready   (imem_ready),
      .stall        (stall),
      .branch_taken (branch_taken),
      .instr        (instr),
      .instr_op     (instr_op),
      .imm_sext     (imm_sext),
      .instr_valid  (instr_valid),
      .pc           (pc),
      .pc_plus4     (pc_plus4),
      .fetch_count  (fetch_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // An instruction slot that is either empty (waiting on memory) or full
   // (waiting for release); the PC advances by one word or by a signed
   // word offset when a full slot is released.
   bit          m_known = 1'b0;
   bit          m_full;
   logic [31:0] m_word;
   logic [31:0] m_pc;
   logic [31:0] m_count;

   always @(posedge clk) begin
      shortint off;
      if (rst) begin
         m_known = 1'b1;
         m_full  = 1'b0;
         m_word  = 32'h0;
         m_pc    = TB_RESET_PC & ~32'd3;
         m_count = 32'd0;
      end else if (m_known) begin
         if (!m_full) begin
            if (imem_ready === 1'b1) begin
               m_full = 1'b1;
               m_word = imem_rdata;
            end
         end else if (stall === 1'b0) begin
            off = m_word[15:0];
            if (branch_taken === 1'b1)
               m_pc = m_pc + 32'd4 + 32'(int'(off) * 4);
            else
               m_pc = m_pc + 32'd4;
            m_count = m_count + 32'd1;
            m_full  = 1'b0;
            m_word  = 32'h0;
         end
      end
   end

   always @(negedge clk) begin
      logic [31:0] e_instr;
      shortint     e_off;
      logic        e_req;
      if (m_known) begin
         e_instr = m_full ? m_word : 32'h0;
         e_off   = e_instr[15:0];
         e_req   = !rst && !m_full;
         chk("mdl_req", {31'b0, imem_req}, {31'b0, e_req});
         if (e_req) chk("mdl_addr", imem_addr, m_pc);
         chk("mdl_valid", {31'b0, instr_valid}, {31'b0, m_full});
         chk("mdl_instr", instr, e_instr);
         chk("mdl_op", {26'b0, instr_op}, {26'b0, e_instr[31:26]});
         chk("mdl_imm", imm_sext, 32'(int'(e_off)));
         chk("mdl_pc", pc, m_pc);
         chk("mdl_pc4", pc_plus4, m_pc + 32'd4);
         chk("mdl_cnt", fetch_count, m_count);
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Called with the DUT in FETCH; serves one word after 'waits' idle cycles
   task automatic fetch_one(input logic [31:0] word, input int waits, input logic [31:0] exp_addr);
      chk("fetch_req", {31'b0, imem_req}, 32'd1);
      chk("fetch_addr", imem_addr, exp_addr);
      for (int i = 0; i < waits; i++) begin
         imem_ready = 1'b0;
         imem_rdata = $urandom;
         step();
         chk("wait_req", {31'b0, imem_req}, 32'd1);
         chk("wait_addr", imem_addr, exp_addr);
         chk("wait_valid", {31'b0, instr_valid}, 32'd0);
         chk("wait_instr", instr, 32'h0);
      end
      imem_ready = 1'b1;
      imem_rdata = word;
      step();
      imem_ready = 1'b0;
      imem_rdata = $urandom;
      chk("cap_valid", {31'b0, instr_valid}, 32'd1);
      chk("cap_instr", instr, word);
      chk("cap_pc", pc, exp_addr);
      chk("cap_req", {31'b0, imem_req}, 32'd0);
   endtask

   // Called in DELIVER; stalls with noisy branch/ready, then releases
   task automatic release_instr(input int stalls, input logic br,
                                input logic [31:0] exp_next, input logic [31:0] exp_cnt);
      logic [31:0] held;
      held = instr;
      for (int i = 0; i < stalls; i++) begin
         stall        = 1'b1;
         branch_taken = i[0];
         imem_ready   = ~i[0];
         step();
         chk("stall_req", {31'b0, imem_req}, 32'd0);
         chk("stall_instr", instr, held);
      end
      stall        = 1'b0;
      branch_taken = br;
      imem_ready   = 1'b0;
      step();
      branch_taken = 1'b0;
      chk("rel_valid", {31'b0, instr_valid}, 32'd0);
      chk("rel_instr", instr, 32'h0);
      chk("rel_addr", imem_addr, exp_next);
      chk("rel_cnt", fetch_count, exp_cnt);
      chk("rel_req", {31'b0, imem_req}, 32'd1);
   endtask

   initial begin
      rst          = 1'b1;
      imem_ready   = 1'b0;
      imem_rdata   = 32'hDEAD_BEEF;
      stall        = 1'b0;
      branch_taken = 1'b0;
      repeat (2) step();
      chk("rst_req", {31'b0, imem_req}, 32'd0);
      chk("rst_valid", {31'b0, instr_valid}, 32'd0);
      chk("rst_cnt", fetch_count, 32'd0);
      chk("rst_instr", instr, 32'h0);
      chk("rst_pc", pc, 32'h40);
      rst = 1'b0;
      #1;

      // LW at reset PC, zero-wait memory
      fetch_one(32'h8C01_0004, 0, 32'h40);
      chk("lw_op", {26'b0, instr_op}, 32'h23);
      chk("lw_imm", imm_sext, 32'd4);
      chk("lw_pc4", pc_plus4, 32'h44);
      chk("lw_cnt", fetch_count, 32'd0);
      release_instr(5, 1'b0, 32'h44, 32'd1);

      // forward branch to 0x100 after a 3-cycle memory wait
      fetch_one(32'h1000_002E, 3, 32'h44);
      release_instr(0, 1'b1, 32'h100, 32'd2);

      // backward BEQ: 0x104 + (-2<<2) = 0x0FC
      fetch_one(32'h1000_FFFE, 1, 32'h100);
      chk("beq_op", {26'b0, instr_op}, 32'h04);
      chk("beq_imm", imm_sext, 32'hFFFF_FFFE);
      release_instr(2, 1'b1, 32'h0FC, 32'd3);

      // ADDI not taken, back to 0x100
      fetch_one(32'h2001_0005, 0, 32'h0FC);
      chk("addi_op", {26'b0, instr_op}, 32'h08);
      release_instr(0, 1'b0, 32'h100, 32'd4);

      // forward offset 3 from 0x100: 0x110
      fetch_one(32'h1000_0003, 0, 32'h100);
      release_instr(0, 1'b1, 32'h110, 32'd5);

      // branch to the top word of the address space
      fetch_one(32'h1000_FFBA, 2, 32'h110);
      release_instr(0, 1'b1, 32'hFFFF_FFFC, 32'd6);

      // PC wrap
      fetch_one(32'hAC02_0008, 0, 32'hFFFF_FFFC);
      chk("wrap_pc4", pc_plus4, 32'h0);
      chk("sw_op", {26'b0, instr_op}, 32'h2B);
      release_instr(1, 1'b0, 32'h0, 32'd7);

      // reset during a FETCH wait
      imem_ready = 1'b0;
      step();
      step();
      chk("fw_req", {31'b0, imem_req}, 32'd1);
      rst = 1'b1;
      step();
      chk("rf_req", {31'b0, imem_req}, 32'd0);
      chk("rf_valid", {31'b0, instr_valid}, 32'd0);
      chk("rf_cnt", fetch_count, 32'd0);
      rst = 1'b0;
      #1;
      fetch_one(32'h0022_1820, 2, 32'h40);
      chk("r_op", {26'b0, instr_op}, 32'h00);
      chk("r_cnt", fetch_count, 32'd0);

      // reset during DELIVER
      stall = 1'b1;
      step();
      rst = 1'b1;
      step();
      chk("rd_req", {31'b0, imem_req}, 32'd0);
      chk("rd_valid", {31'b0, instr_valid}, 32'd0);
      chk("rd_cnt", fetch_count, 32'd0);
      chk("rd_instr", instr, 32'h0);
      rst   = 1'b0;
      stall = 1'b0;
      #1;
      fetch_one(32'h8C01_0004, 0, 32'h40);
      release_instr(0, 1'b0, 32'h44, 32'd1);

      step();
      step();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule
